// File: rtl/if_stage_ctrl_pkg.sv
// if_stage_ctrl_pkg: fetch FSM state encodings and the default NOP bubble encoding
package if_stage_ctrl_pkg;
  typedef enum logic [1:0] {
    IF_S_BOOT  = 2'd0,
    IF_S_FETCH = 2'd1,
    IF_S_HOLD  = 2'd2,
    IF_S_DROP  = 2'd3
  } if_state_e;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
endpackage

// File: rtl/if_stage_ctrl_ifid_reg.sv
// if_stage_ctrl_ifid_reg: IF/ID pipeline register with load, hold and bubble insert
module if_stage_ctrl_ifid_reg
  import if_stage_ctrl_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            bubble_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     inst_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     inst_o
);
  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;
  // a bubble beats a load, an idle cycle holds the current contents
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
    end else begin
      valid_q <= bubble_i ? 1'b0 : (load_i ? 1'b1 : valid_q);
      pc_q    <= (load_i && !bubble_i) ? pc_i : pc_q;
      inst_q  <= bubble_i ? NOP_INST : (load_i ? inst_i : inst_q);
    end
  end
  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
endmodule

// File: rtl/if_stage_ctrl.sv
// if_stage_ctrl: fetch FSM, PC and imem handshake feeding IF/ID; IF_PERF_CNT_EN adds stall/kill counters
module if_stage_ctrl
  import if_stage_ctrl_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PC_write,
  input  logic            IFID_write,
  input  logic            IF_kill,
  input  logic            DEC_kill,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [31:0]     ifid_inst
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     kill_count
`endif
);
  if_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, drop_addr_q, drop_addr_d, hold_pc_q, hold_pc_d;
  logic [31:0]     hold_inst_q, hold_inst_d;
  logic            ld;
  logic [XLEN-1:0] ld_pc;
  logic [31:0]     ld_inst;
  // state, pc and the squashed-request / hold buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IF_S_BOOT;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
      hold_pc_q   <= '0;
      hold_inst_q <= NOP_INST;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
    end
  end
  // next state, pc update and IF/ID load selection
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    hold_pc_d   = hold_pc_q;
    hold_inst_d = hold_inst_q;
    imem_req    = 1'b0;
    ld          = 1'b0;
    ld_pc       = pc_q;
    ld_inst     = imem_rdata;
    case (state_q)
      IF_S_BOOT: state_d = IF_S_FETCH;
      IF_S_FETCH: begin
        imem_req = 1'b1;
        if (redirect_valid || IF_kill) begin
          pc_d        = redirect_valid ? redirect_pc : pc_q;
          drop_addr_d = pc_q;
          state_d     = imem_ack ? IF_S_FETCH : IF_S_DROP;
        end else if (imem_ack && IFID_write && !DEC_kill) begin
          ld   = 1'b1;
          pc_d = PC_write ? pc_q + XLEN'(4) : pc_q;
        end else if (imem_ack) begin
          // the held word is already owned, so pc moves past it now; an IF_kill in hold rolls it back
          hold_pc_d   = pc_q;
          hold_inst_d = imem_rdata;
          pc_d        = pc_q + XLEN'(4);
          state_d     = IF_S_HOLD;
        end
      end
      IF_S_HOLD: begin
        ld_pc   = hold_pc_q;
        ld_inst = hold_inst_q;
        if (redirect_valid || IF_kill) begin
          pc_d    = redirect_valid ? redirect_pc : hold_pc_q;
          state_d = IF_S_FETCH;
        end else if (IFID_write && !DEC_kill) begin
          ld      = 1'b1;
          state_d = IF_S_FETCH;
        end
      end
      default: begin
        imem_req = 1'b1;
        pc_d     = redirect_valid ? redirect_pc : pc_q;
        state_d  = imem_ack ? IF_S_FETCH : IF_S_DROP;
      end
    endcase
  end
  assign imem_addr = (state_q == IF_S_DROP) ? drop_addr_q : pc_q;
  if_stage_ctrl_ifid_reg #(.XLEN(XLEN), .NOP_INST(NOP_INST)) u_ifid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (ld),
    .bubble_i (DEC_kill),
    .pc_i     (ld_pc),
    .inst_i   (ld_inst),
    .valid_o  (ifid_valid),
    .pc_o     (ifid_pc),
    .inst_o   (ifid_inst)
  );
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_q, kill_q;
  // free-running wrap-around event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      kill_q  <= '0;
    end else begin
      stall_q <= (!IFID_write && ifid_valid) ? stall_q + 32'd1 : stall_q;
      kill_q  <= (IF_kill || DEC_kill || redirect_valid) ? kill_q + 32'd1 : kill_q;
    end
  end
  assign stall_cycles = stall_q;
  assign kill_count   = kill_q;
`endif
endmodule

// File: tb/tb_if_stage_ctrl.sv
// tb_if_stage_ctrl: directed self-checking bench for if_stage_ctrl
module tb_if_stage_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PC_write = 1'b1, IFID_write = 1'b1, IF_kill = 1'b0, DEC_kill = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc, ifid_inst;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cycles, kill_count;
`endif
  int checks = 0, errors = 0;
  assign imem_rdata = {16'hA5A5, imem_addr[15:0]};
  always #5 clk = ~clk;
  if_stage_ctrl dut (
    .clk(clk), .rst(rst), .PC_write(PC_write), .IFID_write(IFID_write),
    .IF_kill(IF_kill), .DEC_kill(DEC_kill), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ifid_valid(ifid_valid),
    .ifid_pc(ifid_pc), .ifid_inst(ifid_inst)
`ifdef IF_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .kill_count(kill_count)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    imem_ack = 1'b1;
    tick(); tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(ifid_valid), 32'd0);
    chk("rst_inst", ifid_inst, 32'h0000_0013);
    chk("rst_pc", ifid_pc, 32'h0);
    rst = 1'b0;
    tick();
    chk("boot_req", 32'(imem_req), 32'd1);
    chk("addr0", imem_addr, 32'h0);
    chk("boot_valid", 32'(ifid_valid), 32'd0);
    tick();
    chk("addr4", imem_addr, 32'h4);
    chk("ifid_valid1", 32'(ifid_valid), 32'd1);
    chk("ifid_pc0", ifid_pc, 32'h0);
    chk("ifid_inst0", ifid_inst, 32'hA5A5_0000);
    tick();
    chk("addr8", imem_addr, 32'h8);
    chk("ifid_pc4", ifid_pc, 32'h4);
    PC_write = 1'b0; IFID_write = 1'b0;
    tick();
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("hold_pc4a", ifid_pc, 32'h4);
    tick();
    chk("hold_req2", 32'(imem_req), 32'd0);
    chk("hold_pc4b", ifid_pc, 32'h4);
    PC_write = 1'b1; IFID_write = 1'b1;
    tick();
    chk("unhold_pc8", ifid_pc, 32'h8);
    chk("unhold_inst8", ifid_inst, 32'hA5A5_0008);
    chk("addr12", imem_addr, 32'hC);
    chk("unhold_req", 32'(imem_req), 32'd1);
    tick();
    chk("ifid_pc12", ifid_pc, 32'hC);
    chk("addr16", imem_addr, 32'h10);
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("drop_addr_a", imem_addr, 32'h10);
    chk("drop_req_a", 32'(imem_req), 32'd1);
    tick();
    chk("drop_addr_b", imem_addr, 32'h10);
    tick();
    chk("drop_addr_c", imem_addr, 32'h10);
    imem_ack = 1'b1;
    tick();
    chk("redir_addr", imem_addr, 32'h100);
    chk("drop_ifid_pc", ifid_pc, 32'hC);
    tick();
    chk("redir_ifid_pc", ifid_pc, 32'h100);
    chk("addr104", imem_addr, 32'h104);
    DEC_kill = 1'b1; IFID_write = 1'b0; PC_write = 1'b0; imem_ack = 1'b0;
    tick();
    chk("kill_valid", 32'(ifid_valid), 32'd0);
    chk("kill_inst", ifid_inst, 32'h0000_0013);
    chk("kill_addr", imem_addr, 32'h104);
    DEC_kill = 1'b0; IFID_write = 1'b1; PC_write = 1'b1; imem_ack = 1'b1;
    tick();
    chk("after_kill_pc", ifid_pc, 32'h104);
    chk("after_kill_valid", 32'(ifid_valid), 32'd1);
    IF_kill = 1'b1;
    tick();
    IF_kill = 1'b0;
    chk("ifkill_addr", imem_addr, 32'h108);
    chk("ifkill_ifid_pc", ifid_pc, 32'h104);
    IFID_write = 1'b0; PC_write = 1'b0;
    tick();
    chk("hold2_req", 32'(imem_req), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0; IFID_write = 1'b1; PC_write = 1'b1;
    chk("rst_hold_req", 32'(imem_req), 32'd0);
    chk("rst_hold_valid", 32'(ifid_valid), 32'd0);
    tick();
    chk("reboot_req", 32'(imem_req), 32'd1);
    chk("reboot_addr", imem_addr, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("redir_ack_valid", 32'(ifid_valid), 32'd0);
    tick();
    chk("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
    chk("wrap_to0", imem_addr, 32'h0);
    PC_write = 1'b0;
    tick();
    PC_write = 1'b1;
    chk("refetch_ifid_pc", ifid_pc, 32'h0);
    chk("refetch_addr", imem_addr, 32'h0);
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0; imem_ack = 1'b1;
    chk("dbl_drop_addr", imem_addr, 32'h0);
    tick();
    chk("dbl_redir_addr", imem_addr, 32'h300);
`ifdef IF_PERF_CNT_EN
    rst = 1'b1;
    tick();
    chk("perf_rst_stall", stall_cycles, 32'd0);
    chk("perf_rst_kill", kill_count, 32'd0);
    rst = 1'b0;
    tick(); tick();
    imem_ack = 1'b0; IFID_write = 1'b0; PC_write = 1'b0;
    tick(); tick(); tick();
    IFID_write = 1'b1; PC_write = 1'b1; IF_kill = 1'b1;
    tick();
    IF_kill = 1'b0;
    chk("perf_stall", stall_cycles, 32'd3);
    chk("perf_kill", kill_count, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("perf_clr_stall", stall_cycles, 32'd0);
    chk("perf_clr_kill", kill_count, 32'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
